// File: rtl/seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg_scan_decoder
//
// Receive side of a multiplexed, active-low 7-segment scan bus. The scanning
// source drives one digit enable low at a time together with that digit's
// cathode pattern. This block waits until the pins have been quiet for SETTLE
// samples, then latches the pattern into that digit's register. The result is
// eight static segment buses. A digit that is not refreshed within TIMEOUT
// cycles goes stale and reads as blank (8'hFF).
//
// Parameters
//   SETTLE  : consecutive identical synced samples needed before a capture (>= 2)
//   TIMEOUT : cycles without refresh before a digit goes stale
//   ERR_W   : width of the illegal-enable error counter
//
// Ports
//   clk          in   1      sole clock, rising edge
//   rst          in   1      synchronous reset, active-low
//   an           in   8      digit enables, active-low, asynchronous to clk
//   cath         in   8      {DP,G,F,E,D,C,B,A}, active-low, asynchronous to clk
//   seg0..seg7   out  8      reconstructed segments, active-low, 8'hFF = blank
//   valid        out  8      bit i set while digit i is fresh
//   err_cnt      out  ERR_W  saturating count of entries into multi-low AN patterns
// -----------------------------------------------------------------------------
module seg_scan_decoder #(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 200000,
  parameter int ERR_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       an,
  input  logic [7:0]       cath,
  output logic [7:0]       seg0,
  output logic [7:0]       seg1,
  output logic [7:0]       seg2,
  output logic [7:0]       seg3,
  output logic [7:0]       seg4,
  output logic [7:0]       seg5,
  output logic [7:0]       seg6,
  output logic [7:0]       seg7,
  output logic [7:0]       valid,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int CNT_W = $clog2(SETTLE + 1);
  localparam int AGE_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLING,
    CAPTURED
  } state_e;

  // ---------------------------------------------------------------------------
  // Input synchronizers
  // ---------------------------------------------------------------------------
  // NOTE: two flops in series per bit give a metastable first stage a full
  // cycle to resolve; nothing downstream may look at the first stage.
  logic [7:0] an_meta_q, an_s_q;
  logic [7:0] cath_meta_q, cath_s_q;

  // NOTE: every clocked register uses non-blocking assignment so all flops
  // sample their inputs from the same edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      an_meta_q   <= 8'hFF;
      an_s_q      <= 8'hFF;
      cath_meta_q <= 8'hFF;
      cath_s_q    <= 8'hFF;
    end else begin
      an_meta_q   <= an;
      an_s_q      <= an_meta_q;
      cath_meta_q <= cath;
      cath_s_q    <= cath_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Stability tracking
  // ---------------------------------------------------------------------------
  logic [15:0]      prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             same;
  logic             onehot_low;
  logic             illegal;
  logic             illegal_entry;
  logic             settle_hit;

  assign same       = ({an_s_q, cath_s_q} == prev_q);
  assign onehot_low = $onehot(~an_s_q);
  assign illegal    = (an_s_q != 8'hFF) && !onehot_low;
  // Counted once when an illegal pattern first appears, not while it is held.
  assign illegal_entry = illegal && (an_s_q != prev_q[15:8]);

  // NOTE: each combinational block assigns a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    cnt_d = '0;
    if (same) begin
      cnt_d = (cnt_q == CNT_W'(SETTLE)) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  // The counter reaches SETTLE-1 on the last of the SETTLE stable samples,
  // which places the capture 2 + SETTLE edges after the pins settle.
  assign settle_hit = same && (cnt_d == CNT_W'(SETTLE - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_q <= 16'hFFFF;
      cnt_q  <= '0;
    end else begin
      prev_q <= {an_s_q, cath_s_q};
      cnt_q  <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Capture FSM: state register / next state / output
  // ---------------------------------------------------------------------------
  state_e state_q, state_d;
  logic   capture;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!onehot_low) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:     state_d = SETTLING;
        SETTLING: if (settle_hit) state_d = CAPTURED;
        CAPTURED: if (!same)      state_d = SETTLING;
        default:  state_d = IDLE;
      endcase
    end
  end

  // Only the SETTLING->CAPTURED transition writes, so a held pattern is
  // captured exactly once. An illegal entry in the same cycle vetoes it.
  always_comb begin
    capture = (state_q == SETTLING) && onehot_low && settle_hit && !illegal_entry;
  end

  // ---------------------------------------------------------------------------
  // Per-digit storage, ageing and validity
  // ---------------------------------------------------------------------------
  logic [7:0]       seg_q [8];
  logic [AGE_W-1:0] age_q [8];
  logic [AGE_W-1:0] age_d [8];
  logic [7:0]       valid_q, valid_d;
  logic [7:0]       cap_vec;

  assign cap_vec = capture ? ~an_s_q : 8'h00;

  // A capture on the cycle the age would reach TIMEOUT wins: age restarts
  // at zero and the digit stays valid.
  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < 8; i++) begin
      age_d[i] = '0;
      if (cap_vec[i]) begin
        age_d[i]   = '0;
        valid_d[i] = 1'b1;
      end else begin
        age_d[i] = (age_q[i] == AGE_W'(TIMEOUT)) ? age_q[i] : age_q[i] + AGE_W'(1);
        if (age_d[i] == AGE_W'(TIMEOUT)) valid_d[i] = 1'b0;
      end
    end
  end

  // NOTE: the digit registers are a small flop array, not RAM, and must come
  // out of reset blank, so they are reset alongside the rest of the state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 8'h00;
      for (int i = 0; i < 8; i++) begin
        seg_q[i] <= 8'hFF;
        age_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < 8; i++) begin
        if (cap_vec[i]) seg_q[i] <= cath_s_q;
        age_q[i] <= age_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Error counter
  // ---------------------------------------------------------------------------
  logic [ERR_W-1:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (illegal_entry && (err_q != '1)) err_d = err_q + ERR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) err_q <= '0;
    else      err_q <= err_d;
  end

  // ---------------------------------------------------------------------------
  // Outputs: stale digits read blank
  // ---------------------------------------------------------------------------
  logic [7:0] seg_out [8];

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      seg_out[i] = valid_q[i] ? seg_q[i] : 8'hFF;
    end
  end

  assign seg0    = seg_out[0];
  assign seg1    = seg_out[1];
  assign seg2    = seg_out[2];
  assign seg3    = seg_out[3];
  assign seg4    = seg_out[4];
  assign seg5    = seg_out[5];
  assign seg6    = seg_out[6];
  assign seg7    = seg_out[7];
  assign valid   = valid_q;
  assign err_cnt = err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_decoder
//
// Directed bench for seg_scan_decoder. Two instances share the stimulus:
// dut uses default parameters, dut_to uses TIMEOUT=50 and ERR_W=2 so that
// staleness and error-counter saturation are reachable in a short run.
// Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_seg_scan_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] an;
  logic [7:0] cath;

  logic [7:0] seg   [8];
  logic [7:0] valid;
  logic [7:0] err_cnt;

  logic [7:0] seg_t [8];
  logic [7:0] valid_t;
  logic [1:0] err_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Active-low 7-segment codes for digits 0..7.
  logic [7:0] codes [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

  always #5 clk = ~clk;

  seg_scan_decoder dut (
    .clk    (clk),
    .rst    (rst),
    .an     (an),
    .cath   (cath),
    .seg0   (seg[0]),
    .seg1   (seg[1]),
    .seg2   (seg[2]),
    .seg3   (seg[3]),
    .seg4   (seg[4]),
    .seg5   (seg[5]),
    .seg6   (seg[6]),
    .seg7   (seg[7]),
    .valid  (valid),
    .err_cnt(err_cnt)
  );

  seg_scan_decoder #(.TIMEOUT(50), .ERR_W(2)) dut_to (
    .clk    (clk),
    .rst    (rst),
    .an     (an),
    .cath   (cath),
    .seg0   (seg_t[0]),
    .seg1   (seg_t[1]),
    .seg2   (seg_t[2]),
    .seg3   (seg_t[3]),
    .seg4   (seg_t[4]),
    .seg5   (seg_t[5]),
    .seg6   (seg_t[6]),
    .seg7   (seg_t[7]),
    .valid  (valid_t),
    .err_cnt(err_t)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance n falling edges; after step(k) the k-th rising edge since the
  // last drive has been taken.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst  = 1'b0;
    an   = 8'hFF;
    cath = 8'hFF;
    step(3);

    // Reset state
    for (int i = 0; i < 8; i++) check($sformatf("rst_seg%0d", i), seg[i], 8'hFF);
    check("rst_valid", valid, 8'h00);
    check("rst_err", err_cnt, 8'h00);

    // Single digit capture with exact latency
    rst  = 1'b1;
    an   = 8'hFB;
    cath = 8'hA4;
    step(5);
    check("lat_seg2_before", seg[2], 8'hFF);
    check("lat_valid_before", valid, 8'h00);
    step(1);
    check("lat_seg2_at6", seg[2], 8'hA4);
    check("lat_valid_at6", valid, 8'h04);
    step(4);
    check("lat_seg2_hold", seg[2], 8'hA4);
    check("lat_seg0_blank", seg[0], 8'hFF);
    check("lat_seg7_blank", seg[7], 8'hFF);
    check("lat_valid_hold", valid, 8'h04);

    // Cathodes toggling faster than the settle window never capture
    an = 8'hFF;
    step(4);
    an = 8'hFE;
    for (int k = 0; k < 8; k++) begin
      cath = k[0] ? 8'hF9 : 8'hC0;
      step(3);
    end
    an = 8'hFF;
    step(6);
    check("tog_seg0", seg[0], 8'hFF);
    check("tog_valid", valid, 8'h04);

    // Full scan of all eight digits
    for (int d = 0; d < 8; d++) begin
      an   = ~(8'h01 << d);
      cath = codes[d];
      step(8);
    end
    an = 8'hFF;
    step(4);
    for (int i = 0; i < 8; i++) check($sformatf("scan_seg%0d", i), seg[i], codes[i]);
    check("scan_valid", valid, 8'hFF);
    check("scan_err", err_cnt, 8'h00);

    // Illegal enables count once per entry and never capture
    an   = 8'hFC;
    cath = 8'h00;
    step(20);
    check("ill_err_first", err_cnt, 8'h01);
    an = 8'hFF;
    step(5);
    an = 8'hFC;
    step(5);
    check("ill_err", err_cnt, 8'h02);
    check("ill_err_t", err_t, 2'd2);
    check("ill_valid", valid, 8'hFF);
    check("ill_seg0", seg[0], 8'hC0);
    check("ill_seg1", seg[1], 8'hF9);
    an = 8'hFF;
    step(3);
    an = 8'hFC;
    step(3);
    check("ill_err_t_max", err_t, 2'd3);
    an = 8'hFF;
    step(3);
    an = 8'hF0;
    step(3);
    check("ill_err_4", err_cnt, 8'h04);
    check("ill_err_t_sat", err_t, 2'd3);

    // Staleness at exactly TIMEOUT (dut_to) without recapture while held
    an   = 8'hDF;
    cath = 8'h92;
    step(6);
    check("age_valid5_cap", valid_t[5], 1'b1);
    check("age_seg5_cap", seg_t[5], 8'h92);
    step(14);
    an = 8'hFF;
    step(35);
    check("age_valid5_49", valid_t[5], 1'b1);
    check("age_seg5_49", seg_t[5], 8'h92);
    step(1);
    check("age_valid5_50", valid_t[5], 1'b0);
    check("age_seg5_50", seg_t[5], 8'hFF);
    check("age_main_valid", valid, 8'hFF);

    // Reset inside digit 3's settle window
    an   = 8'hF7;
    cath = 8'hB0;
    step(2);
    rst = 1'b0;
    step(1);
    check("rst3_seg3", seg[3], 8'hFF);
    check("rst3_valid", valid, 8'h00);
    check("rst3_err", err_cnt, 8'h00);
    rst = 1'b1;
    step(5);
    check("rst3_seg3_before", seg[3], 8'hFF);
    step(1);
    check("rst3_seg3_cap", seg[3], 8'hB0);
    check("rst3_valid_cap", valid, 8'h08);
    check("rst3_seg3_t", seg_t[3], 8'hB0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
